// File: rtl/apb_timeout_node_pkg.sv
// Shared types and constants for the APB timeout fan-out node.
package apb_node_pkg;

    // Transfer-level FSM: where the node is in the current APB transfer.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,  // waiting for a setup phase
        ACCESS = 2'd1,  // transfer routed to a decoded slave
        DECERR = 2'd2,  // address matched no region
        ABORT  = 2'd3   // slave stalled past the timeout budget
    } node_state_e;

    // Read data returned on decode errors and timeout aborts.
    localparam int unsigned ERR_RDATA = 0;

endpackage

// File: rtl/apb_timeout_node_if.sv
// Bus bundle around the node: upstream APB port from the bridge plus the
// shared downstream APB port towards the peripherals.
//
// Handshake: APB two-phase. A transfer starts with a setup cycle
// (psel=1, penable=0), followed by one or more access cycles
// (psel=1, penable=1). The transfer completes in the first access cycle
// with pready=1; prdata and pslverr are only meaningful in that cycle.
interface apb_timeout_node_if #(
    parameter int NB_SLAVES      = 4,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32
);
    // Upstream request from the bridge
    logic [APB_ADDR_WIDTH-1:0]           paddr_i;
    logic [APB_DATA_WIDTH-1:0]           pwdata_i;
    logic                                pwrite_i;
    logic                                psel_i;
    logic                                penable_i;
    // Upstream response to the bridge
    logic [APB_DATA_WIDTH-1:0]           prdata_o;
    logic                                pready_o;
    logic                                pslverr_o;
    // Shared downstream request
    logic [APB_ADDR_WIDTH-1:0]           paddr_o;
    logic [APB_DATA_WIDTH-1:0]           pwdata_o;
    logic                                pwrite_o;
    logic                                penable_o;
    logic [NB_SLAVES-1:0]                psel_o;
    // Per-slave responses
    logic [NB_SLAVES*APB_DATA_WIDTH-1:0] prdata_i;
    logic [NB_SLAVES-1:0]                pready_i;
    logic [NB_SLAVES-1:0]                pslverr_i;

    // Node side
    modport slave (
        input  paddr_i, pwdata_i, pwrite_i, psel_i, penable_i,
        output prdata_o, pready_o, pslverr_o,
        output paddr_o, pwdata_o, pwrite_o, penable_o, psel_o,
        input  prdata_i, pready_i, pslverr_i
    );

    // Environment side (bridge + peripherals)
    modport master (
        output paddr_i, pwdata_i, pwrite_i, psel_i, penable_i,
        input  prdata_o, pready_o, pslverr_o,
        input  paddr_o, pwdata_o, pwrite_o, penable_o, psel_o,
        output prdata_i, pready_i, pslverr_i
    );
endinterface

// File: rtl/apb_timeout_node_decoder.sv
// Address region decoder: inclusive start/end match per slave, lowest
// index wins when regions overlap.
module apb_addr_decoder
    import apb_node_pkg::*;
#(
    parameter int NB_SLAVES      = 4,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int IDX_W          = (NB_SLAVES > 1) ? $clog2(NB_SLAVES) : 1
) (
    input  logic [APB_ADDR_WIDTH-1:0]           addr_i,
    input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] start_addr_i,
    input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] end_addr_i,
    output logic                                hit,
    output logic [IDX_W-1:0]                    idx
);

    // Walk from highest to lowest index so the lowest matching one is kept.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int k = NB_SLAVES - 1; k >= 0; k--) begin
            if ((addr_i >= start_addr_i[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]) &&
                (addr_i <= end_addr_i[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH])) begin
                hit = 1'b1;
                idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/apb_timeout_node.sv
// APB fan-out node with decode-error and stall-timeout termination, so the
// upstream bridge always sees every transfer complete.
module apb_timeout_node
    import apb_node_pkg::*;
#(
    parameter int NB_SLAVES      = 4,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] start_addr_i,
    input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0] end_addr_i,
    apb_timeout_node_if.slave                   bus,
    output logic                                timeout_o,
    output node_state_e                         state_o
);

    localparam int IDX_W = (NB_SLAVES > 1) ? $clog2(NB_SLAVES) : 1;

    node_state_e             state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]        sel_q, sel_d;
    logic                    timeout_q, timeout_d;

    logic                    dec_hit;
    logic [IDX_W-1:0]        dec_idx;
    logic                    setup;
    logic                    sel_ready;
    logic                    sel_slverr;
    logic [APB_DATA_WIDTH-1:0] sel_rdata;

    logic [APB_DATA_WIDTH-1:0] prdata;
    logic                    pready;
    logic                    pslverr;
    logic [NB_SLAVES-1:0]    psel;

    apb_addr_decoder #(
        .NB_SLAVES      (NB_SLAVES),
        .APB_ADDR_WIDTH (APB_ADDR_WIDTH),
        .IDX_W          (IDX_W)
    ) u_decoder (
        .addr_i       (bus.paddr_i),
        .start_addr_i (start_addr_i),
        .end_addr_i   (end_addr_i),
        .hit          (dec_hit),
        .idx          (dec_idx)
    );

    assign setup = bus.psel_i && !bus.penable_i;

    // Pick the response lines of the slave latched for this transfer.
    always_comb begin
        sel_ready  = 1'b0;
        sel_slverr = 1'b0;
        sel_rdata  = '0;
        for (int k = 0; k < NB_SLAVES; k++) begin
            if (sel_q == IDX_W'(k)) begin
                sel_ready  = bus.pready_i[k];
                sel_slverr = bus.pslverr_i[k];
                sel_rdata  = bus.prdata_i[k*APB_DATA_WIDTH +: APB_DATA_WIDTH];
            end
        end
    end

    // State, wait counter, latched slave index and timeout pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sel_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic; the counter only advances on stalled access cycles
    // and stops at TIMEOUT_CYCLES, where the next stall triggers the abort.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (setup) begin
                    if (dec_hit) begin
                        state_d = ACCESS;
                        sel_d   = dec_idx;
                        cnt_d   = '0;
                    end else begin
                        state_d = DECERR;
                    end
                end
            end
            ACCESS: begin
                if (!bus.psel_i) begin
                    // Bridge abandoned the transfer; drop it quietly.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (bus.penable_i) begin
                    if (sel_ready) begin
                        state_d = IDLE;
                    end else if (cnt_q < CNT_WIDTH'(TIMEOUT_CYCLES)) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end else begin
                        state_d   = ABORT;
                        timeout_d = 1'b1;
                    end
                end
            end
            DECERR: begin
                if (!bus.psel_i || bus.penable_i) begin
                    state_d = IDLE;
                end
            end
            ABORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: downstream select and upstream response per state.
    always_comb begin
        prdata  = '0;
        pready  = 1'b0;
        pslverr = 1'b0;
        psel    = '0;
        unique case (state_q)
            IDLE: begin
                if (setup && dec_hit) begin
                    psel = NB_SLAVES'(1) << dec_idx;
                end
            end
            ACCESS: begin
                psel = NB_SLAVES'(1) << sel_q;
                if (bus.psel_i && bus.penable_i && sel_ready) begin
                    pready  = 1'b1;
                    pslverr = sel_slverr;
                    prdata  = sel_rdata;
                end
            end
            DECERR: begin
                if (bus.psel_i && bus.penable_i) begin
                    pready  = 1'b1;
                    pslverr = 1'b1;
                    prdata  = APB_DATA_WIDTH'(ERR_RDATA);
                end
            end
            ABORT: begin
                pready  = 1'b1;
                pslverr = 1'b1;
                prdata  = APB_DATA_WIDTH'(ERR_RDATA);
            end
            default: begin
                pready = 1'b0;
            end
        endcase
    end

    assign bus.prdata_o  = prdata;
    assign bus.pready_o  = pready;
    assign bus.pslverr_o = pslverr;
    assign bus.psel_o    = psel;

    // Request fields are shared by all slaves and pass straight through.
    assign bus.paddr_o   = bus.paddr_i;
    assign bus.pwdata_o  = bus.pwdata_i;
    assign bus.pwrite_o  = bus.pwrite_i;
    assign bus.penable_o = bus.penable_i;

    assign timeout_o = timeout_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_apb_timeout_node.sv
// Bench for apb_timeout_node: transfer-level reference model, per-cycle
// scoreboard compare, directed checks from the test plan, random traffic.
module tb_apb_timeout_node;
    import apb_node_pkg::*;

    localparam int NS  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    typedef struct packed {
        logic [NS-1:0] psel;
        logic          pready;
        logic          pslverr;
        logic [DW-1:0] prdata;
        logic          timeout;
        logic [AW-1:0] paddr;
        logic [DW-1:0] pwdata;
        logic          pwrite;
        logic          penable;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    logic clk;
    logic rst_ni;
    logic timeout;
    node_state_e state;
    logic [NS*AW-1:0] start_addr;
    logic [NS*AW-1:0] end_addr;
    logic [AW-1:0] reg_start [NS];
    logic [AW-1:0] reg_end   [NS];
    logic [AW-1:0] unmapped  [3];

    logic [EXP_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Completion observations for the directed checks
    int          cur_acc  = 0;
    int          seen_len = 0;
    logic [NS-1:0] seen_psel;
    logic        seen_err;
    logic [DW-1:0] seen_data;
    int          tmo_cnt  = 0;

    apb_timeout_node_if #(.NB_SLAVES(NS), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) bus ();

    apb_timeout_node #(
        .NB_SLAVES(NS), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .start_addr_i (start_addr),
        .end_addr_i   (end_addr),
        .bus          (bus),
        .timeout_o    (timeout),
        .state_o      (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NS; k++) begin
            start_addr[k*AW +: AW] = reg_start[k];
            end_addr[k*AW +: AW]   = reg_end[k];
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: first region (ascending index) containing the address.
    function automatic int find_slave(input logic [AW-1:0] a);
        for (int k = 0; k < NS; k++) begin
            if (a >= reg_start[k] && a <= reg_end[k]) return k;
        end
        return -1;
    endfunction

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_t'(exp_q.pop_front());
            chk("psel_o",    64'(bus.psel_o),    64'(e.psel));
            chk("pready_o",  64'(bus.pready_o),  64'(e.pready));
            chk("pslverr_o", 64'(bus.pslverr_o), 64'(e.pslverr));
            chk("prdata_o",  64'(bus.prdata_o),  64'(e.prdata));
            chk("timeout_o", 64'(timeout),       64'(e.timeout));
            chk("paddr_o",   64'(bus.paddr_o),   64'(e.paddr));
            chk("pwdata_o",  64'(bus.pwdata_o),  64'(e.pwdata));
            chk("pwrite_o",  64'(bus.pwrite_o),  64'(e.pwrite));
            chk("penable_o", 64'(bus.penable_o), 64'(e.penable));
        end
        if (rst_ni && bus.pready_o === 1'b1) begin
            seen_len  = cur_acc;
            seen_psel = bus.psel_o;
            seen_err  = bus.pslverr_o;
            seen_data = bus.prdata_o;
        end
        if (timeout === 1'b1) tmo_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic randomize_slaves();
        for (int k = 0; k < NS; k++) bus.prdata_i[k*DW +: DW] = $urandom;
        bus.pready_i  = NS'($urandom_range(0, 15));
        bus.pslverr_i = NS'($urandom_range(0, 15));
    endtask

    function automatic exp_t base_exp();
        exp_t e;
        e         = '0;
        e.paddr   = bus.paddr_i;
        e.pwdata  = bus.pwdata_i;
        e.pwrite  = bus.pwrite_i;
        e.penable = bus.penable_i;
        return e;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            cur_acc       = 0;
            bus.psel_i    = 1'b0;
            bus.penable_i = 1'b0;
            randomize_slaves();
            exp_q.push_back(EXP_W'(base_exp()));
        end
    endtask

    // One APB transfer. ready_at: access cycle where the target slave raises
    // pready (0 = never). rst_at: access cycle in which reset is pulsed (0 = none).
    task automatic do_xfer(input logic [AW-1:0] addr, input logic wr, input int ready_at,
                           input logic err, input logic [DW-1:0] rdata, input int rst_at);
        int k;
        logic [NS-1:0] oh;
        exp_t e;
        bit done;
        k    = find_slave(addr);
        oh   = (k >= 0) ? NS'(1) << k : '0;
        done = 1'b0;
        @(posedge clk); #1;
        seen_len      = 0;
        cur_acc       = 0;
        bus.psel_i    = 1'b1;
        bus.penable_i = 1'b0;
        bus.paddr_i   = addr;
        bus.pwrite_i  = wr;
        bus.pwdata_i  = $urandom;
        randomize_slaves();
        e      = base_exp();
        e.psel = oh;
        exp_q.push_back(EXP_W'(e));
        for (int c = 1; c <= TMO + 2 && !done; c++) begin
            @(posedge clk); #1;
            cur_acc       = c;
            bus.penable_i = 1'b1;
            randomize_slaves();
            if (k >= 0) begin
                bus.prdata_i[k*DW +: DW] = rdata;
                bus.pslverr_i[k]         = err;
                bus.pready_i[k]          = (ready_at != 0 && c >= ready_at);
            end
            if (c == rst_at) begin
                rst_ni = 1'b0;
                #1;
                chk("rst_psel_o",    64'(bus.psel_o),    64'(0));
                chk("rst_pready_o",  64'(bus.pready_o),  64'(0));
                chk("rst_pslverr_o", 64'(bus.pslverr_o), 64'(0));
                chk("rst_prdata_o",  64'(bus.prdata_o),  64'(0));
                chk("rst_timeout_o", 64'(timeout),       64'(0));
                cur_acc       = 0;
                bus.psel_i    = 1'b0;
                bus.penable_i = 1'b0;
                @(posedge clk); #1;
                rst_ni = 1'b1;
                return;
            end
            e = base_exp();
            if (k < 0) begin
                e.pready  = 1'b1;
                e.pslverr = 1'b1;
                done      = 1'b1;
            end else if (ready_at != 0 && ready_at <= TMO + 1 && c == ready_at) begin
                e.psel    = oh;
                e.pready  = 1'b1;
                e.pslverr = err;
                e.prdata  = rdata;
                done      = 1'b1;
            end else if (c == TMO + 2) begin
                e.pready  = 1'b1;
                e.pslverr = 1'b1;
                e.timeout = 1'b1;
                done      = 1'b1;
            end else begin
                e.psel = oh;
            end
            exp_q.push_back(EXP_W'(e));
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        int t0;
        reg_start[0] = 32'h0000_1000; reg_end[0] = 32'h0000_1FFF;
        reg_start[1] = 32'h1A10_0000; reg_end[1] = 32'h1A10_0FFF;
        reg_start[2] = 32'h1A11_0000; reg_end[2] = 32'h1A11_0FFF;
        reg_start[3] = 32'h1A10_0800; reg_end[3] = 32'h1A12_0000;
        unmapped[0]  = 32'h0000_0010;
        unmapped[1]  = 32'h0000_2000;
        unmapped[2]  = 32'hFFFF_0000;

        rst_ni        = 1'b0;
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
        bus.paddr_i   = '0;
        bus.pwdata_i  = '0;
        bus.pwrite_i  = 1'b0;
        bus.prdata_i  = '0;
        bus.pready_i  = '0;
        bus.pslverr_i = '0;
        #3;
        chk("init_psel_o",    64'(bus.psel_o),    64'(0));
        chk("init_pready_o",  64'(bus.pready_o),  64'(0));
        chk("init_pslverr_o", 64'(bus.pslverr_o), 64'(0));
        chk("init_prdata_o",  64'(bus.prdata_o),  64'(0));
        chk("init_timeout_o", 64'(timeout),       64'(0));
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        idle(1);

        // Write to slave 1, ready immediately
        do_xfer(32'h1A10_0004, 1'b1, 1, 1'b0, 32'h1234_5678, 0);
        idle(1);
        chk("t1_len",  64'(seen_len),  64'(1));
        chk("t1_psel", 64'(seen_psel), 64'(4'b0010));
        chk("t1_err",  64'(seen_err),  64'(0));

        // Read from slave 2 (overlaps slave 3), three wait cycles
        t0 = tmo_cnt;
        do_xfer(32'h1A11_0100, 1'b0, 4, 1'b0, 32'hCAFE_F00D, 0);
        idle(1);
        chk("t2_len",  64'(seen_len),      64'(4));
        chk("t2_data", 64'(seen_data),     64'(32'hCAFE_F00D));
        chk("t2_tmo",  64'(tmo_cnt - t0),  64'(0));

        // Unmapped read
        do_xfer(32'h0000_0010, 1'b0, 1, 1'b0, 32'hDEAD_BEEF, 0);
        idle(1);
        chk("t3_len",  64'(seen_len),  64'(1));
        chk("t3_psel", 64'(seen_psel), 64'(0));
        chk("t3_err",  64'(seen_err),  64'(1));
        chk("t3_data", 64'(seen_data), 64'(0));

        // Slave 3 never ready: abort on access cycle TMO+2
        t0 = tmo_cnt;
        do_xfer(32'h1A11_2000, 1'b0, 0, 1'b0, 32'h5555_AAAA, 0);
        idle(1);
        chk("t4_len",  64'(seen_len),     64'(6));
        chk("t4_psel", 64'(seen_psel),    64'(0));
        chk("t4_err",  64'(seen_err),     64'(1));
        chk("t4_tmo",  64'(tmo_cnt - t0), 64'(1));
        do_xfer(32'h0000_1800, 1'b0, 2, 1'b0, 32'h0BAD_F00D, 0);
        idle(1);
        chk("t4b_len",  64'(seen_len),  64'(2));
        chk("t4b_data", 64'(seen_data), 64'(32'h0BAD_F00D));

        // Ready exactly when the counter reaches the limit
        t0 = tmo_cnt;
        do_xfer(32'h1A10_0010, 1'b0, 5, 1'b1, 32'h7777_1111, 0);
        idle(1);
        chk("t5_len",  64'(seen_len),     64'(5));
        chk("t5_err",  64'(seen_err),     64'(1));
        chk("t5_data", 64'(seen_data),    64'(32'h7777_1111));
        chk("t5_tmo",  64'(tmo_cnt - t0), 64'(0));

        // Reset in the middle of a wait, then a fresh long-wait transfer
        do_xfer(32'h1A10_0020, 1'b0, 0, 1'b0, 32'h0, 3);
        idle(1);
        t0 = tmo_cnt;
        do_xfer(32'h1A10_0020, 1'b0, 5, 1'b0, 32'h2468_ACE0, 0);
        idle(1);
        chk("t6_len",  64'(seen_len),     64'(5));
        chk("t6_data", 64'(seen_data),    64'(32'h2468_ACE0));
        chk("t6_tmo",  64'(tmo_cnt - t0), 64'(0));

        // Random traffic, mostly back-to-back
        for (int n = 0; n < 80; n++) begin
            int sel;
            logic [AW-1:0] a;
            sel = $urandom_range(0, NS);
            if (sel == NS) a = unmapped[$urandom_range(0, 2)];
            else a = reg_start[sel] + ($urandom % (reg_end[sel] - reg_start[sel] + 1));
            do_xfer(a, 1'($urandom_range(0, 1)), $urandom_range(0, TMO + 3),
                    1'($urandom_range(0, 1)), $urandom, 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_timeout_node.md
# apb_timeout_node

APB fan-out node sitting directly downstream of the AXI-to-APB bridge. It decodes the bridge's single APB master port onto `NB_SLAVES` peripheral ports. It guarantees every transfer terminates: unmapped addresses and stalled peripherals complete with `PSLVERR`, so the bridge never hangs waiting for `PREADY`.

## Interface
- `NB_SLAVES`, 4: number of downstream APB ports.
- `APB_ADDR_WIDTH`, 32: address width.
- `APB_DATA_WIDTH`, 32: data width.
- `TIMEOUT_CYCLES`, 255: wait cycles allowed before abort; must be ≥1.
- `CNT_WIDTH`, `$clog2(TIMEOUT_CYCLES+1)`: timeout counter width.
- `clk_i`  in  1  single clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `start_addr_i`  in  `NB_SLAVES×APB_ADDR_WIDTH`  inclusive region base per slave.
- `end_addr_i`  in  `NB_SLAVES×APB_ADDR_WIDTH`  inclusive region end per slave.
- `paddr_i`, `pwdata_i`, `pwrite_i`, `psel_i`, `penable_i`  in  AW/DW/1/1/1  upstream APB request (from bridge).
- `prdata_o`, `pready_o`, `pslverr_o`  out  DW/1/1  upstream APB response.
- `paddr_o`, `pwdata_o`, `pwrite_o`, `penable_o`  out  AW/DW/1/1  shared downstream request.
- `psel_o`  out  `NB_SLAVES`  one-hot downstream select.
- `prdata_i`  in  `NB_SLAVES×DW`  per-slave read data.
- `pready_i`, `pslverr_i`  in  `NB_SLAVES` each  per-slave response.
- `timeout_o`  out  1  one-cycle registered pulse per timeout abort.

## Operation
- FSM states:
  - IDLE: wait for setup.
  - ACCESS: transfer routed to a slave.
  - DECERR: address unmapped.
  - ABORT: timeout hit.
- Setup phase (`psel_i=1`, `penable_i=0`) in IDLE: decode `paddr_i` against all regions, with `start ≤ addr ≤ end`.
  - Lowest index wins on overlap.
  - Hit: latch index `sel_q`, clear counter, go to ACCESS.
  - Miss: go to DECERR.
- Request fields `paddr_o`, `pwdata_o`, `pwrite_o` and `penable_o` are combinational copies of their inputs.
- `psel_o[k]` behaviour:
  - During setup: driven from the combinational decode.
  - During ACCESS: driven from `sel_q`.
  - During IDLE, DECERR and ABORT: zero.
- ACCESS, each cycle with `penable_i=1`:
  - `pready_i[sel_q]=1`: forward `prdata`, `pready` and `pslverr` from slave `sel_q`, then go to IDLE.
  - Otherwise, `cnt < TIMEOUT_CYCLES`: `cnt++`, `pready_o=0`.
  - Otherwise, `cnt == TIMEOUT_CYCLES`: go to ABORT.
- DECERR: `pready_o=1`, `pslverr_o=1`, `prdata_o=0` on the first `penable_i=1` cycle, then go to IDLE.
- ABORT, entered registered:
  - Next cycle: `pready_o=1`, `pslverr_o=1`, `prdata_o=0`, `psel_o=0`, go to IDLE.
  - `timeout_o` pulses in the ABORT cycle.
- Counter saturates and never wraps.
- `pslverr_o` is zero whenever `pready_o` is zero.
- `psel_i` dropping without completion (protocol violation): return to IDLE, clear counter.

## Timing
- Reset value of every output is zero: `prdata_o`, `pready_o`, `pslverr_o`, `psel_o`, `timeout_o`. Copied request fields follow their inputs.
- Reset is asynchronous: FSM goes to IDLE, `cnt` and `sel_q` clear. A transfer in flight is dropped with no response.
- Latency:
  - Decoded hit: zero added cycles; `pready_i` propagates combinationally to `pready_o`.
  - Decode miss: completes in the first access cycle.
  - Timeout: completes on access cycle `TIMEOUT_CYCLES+2`. That is `TIMEOUT_CYCLES+1` wait cycles counted, then one ABORT cycle.
- `pready_i` arriving in the same cycle `cnt` reaches `TIMEOUT_CYCLES`: the slave response wins, with no abort and no `timeout_o`.
- Back-to-back transfers: a new setup is accepted in the cycle after completion.

## Structure
- Shared package `apb_node_pkg`:
  - FSM state enum `{IDLE, ACCESS, DECERR, ABORT}`.
  - Error read data constant, 0.
- Sub-module `apb_addr_decoder`: combinational region match with priority encoder. Outputs `hit` and `idx`.
- FSM, counter and response mux stay in the top module.

## Test plan
- Write to `0x1A10_0004`, slave 1 mapped at `0x1A10_0000–0x1A10_0FFF`, `pready_i[1]=1` immediately:
  - `psel_o=4'b0010`.
  - Completes in 1 access cycle.
  - `pslverr_o=0`.
- Read from slave 2 with `pready_i` held low for 3 cycles, `prdata_i[2]=0xCAFE_F00D`:
  - 4 access cycles.
  - `prdata_o=0xCAFE_F00D`.
  - `timeout_o=0`.
- Read from unmapped `0x0000_0010`:
  - `psel_o=0`.
  - `pready_o=1`, `pslverr_o=1`, `prdata_o=0` in first access cycle.
- `TIMEOUT_CYCLES=4`, slave never ready:
  - `pready_o=1`, `pslverr_o=1` on access cycle 6.
  - `timeout_o` pulses once.
  - `psel_o` deasserted that cycle.
  - Next transfer to slave 0 proceeds normally.
- `TIMEOUT_CYCLES=4`, `pready_i` arrives on access cycle 5: slave response returned, no `timeout_o`.
- `rst_ni` asserted mid-wait:
  - All outputs zero immediately.
  - After release, a fresh transfer completes normally with the counter restarted.
